// File: rtl/fifo_read_ctrl_if.sv
// Read-side bus bundle between sync_fifo, fifo_read_ctrl and a downstream consumer.
//   fifo_empty  sync_fifo empty flag
//   fifo_data   sync_fifo data_out, valid the cycle after fifo_rd_en
//   fifo_rd_en  read strobe to sync_fifo
//   m_valid     downstream word available
//   m_data      downstream word
//   m_ready     downstream accepts word
// master: the read controller. slave: the environment around it (FIFO plus consumer).
interface fifo_read_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read-side controller for sync_fifo. Issues rd_en from the empty flag, absorbs
// the FIFO's one-cycle read latency in a 2-entry skid buffer and presents the
// words on a valid/ready stream at full throughput.
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   enable      1 = new FIFO reads may be issued
//   bus         fifo_read_ctrl_if.master (FIFO read port + downstream stream)
//   word_count  completed m_valid && m_ready handshakes, wraps
//   busy        a word is in flight from the FIFO or held in the skid buffer
module fifo_read_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    fifo_read_ctrl_if.master     bus,
    output logic [CNT_WIDTH-1:0] word_count,
    output logic                 busy
);

    logic [1:0]            occ;
    logic                  pend;
    logic [DATA_WIDTH-1:0] skid0;
    logic [DATA_WIDTH-1:0] skid1;
    logic                  pop;
    logic                  rd_en;
    logic [2:0]            level;

    assign pop   = (occ != 2'd0) && bus.m_ready;

    // Occupancy the buffer will have after this cycle's pop, counting the word
    // already in flight. occ + pend never exceeds 2, so 3 bits cannot wrap.
    assign level = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};

    // rst_n is folded in so the strobe is 0 while reset is held, even with
    // enable high and the FIFO non-empty.
    assign rd_en = rst_n && enable && !bus.fifo_empty && (level < 3'd2);

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (occ != 2'd0);
    assign bus.m_data     = skid0;
    assign busy           = (occ != 2'd0) || pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ        <= 2'd0;
            pend       <= 1'b0;
            skid0      <= '0;
            skid1      <= '0;
            word_count <= '0;
        end else begin
            pend       <= rd_en;
            word_count <= word_count + CNT_WIDTH'(pop);
            case ({pop, pend})
                2'b11: begin
                    // Head leaves while the in-flight word lands at the tail.
                    if (occ == 2'd2) begin
                        skid0 <= skid1;
                        skid1 <= bus.fifo_data;
                    end else begin
                        skid0 <= bus.fifo_data;
                    end
                end
                2'b10: begin
                    skid0 <= skid1;
                    occ   <= occ - 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd0) begin
                        skid0 <= bus.fifo_data;
                    end else begin
                        skid1 <= bus.fifo_data;
                    end
                    occ <= occ + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a behavioural sync_fifo read port
// (registered data_out, one-cycle read latency) and an in-order scoreboard.
module tb_fifo_read_ctrl;
    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          enable = 1'b0;
    logic [CW-1:0] word_count;
    logic          busy;

    fifo_read_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    fifo_read_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .bus        (bus),
        .word_count (word_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    int wptr    = 0;
    int rptr    = 0;
    int exp_idx = 0;
    int tests   = 0;
    int fails   = 0;

    assign bus.fifo_empty = (wptr == rptr);

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_data <= mem[rptr[7:0]];
            rptr          <= rptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: each handshake must deliver the next word taken from the FIFO;
    // on reset, words already read but undelivered are forfeited.
    always @(negedge clk or negedge rst_n) begin
        int  inflight;
        logic hs;
        if (!rst_n) begin
            exp_idx = rptr;
        end else begin
            inflight = rptr - exp_idx;
            hs       = bus.m_valid && bus.m_ready;
            if (bus.fifo_rd_en) begin
                chk("no_underflow", {31'd0, bus.fifo_empty}, 32'd0);
                chk("no_overflow", {31'd0, (inflight - int'(hs)) < 2}, 32'd1);
            end
            if (hs) begin
                chk("order", {24'd0, bus.m_data}, {24'd0, mem[exp_idx[7:0]]});
                exp_idx++;
            end
        end
    end

    task automatic push(input logic [7:0] v);
        mem[wptr[7:0]] = v;
        wptr++;
    endtask

    task automatic load8();
        for (int i = 1; i <= 8; i++) push(8'(i));
    endtask

    task automatic do_reset();
        enable      = 1'b0;
        bus.m_ready = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_count(input int n, input int budget, input string tag);
        int c = 0;
        while (word_count != CW'(n) && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(tag, {16'd0, word_count}, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        int rd;
        int base;
        int c;
        bus.m_ready = 1'b0;

        // reset state
        #2;
        chk("rst_rd_en",  {31'd0, bus.fifo_rd_en}, 0);
        chk("rst_valid",  {31'd0, bus.m_valid}, 0);
        chk("rst_data",   {24'd0, bus.m_data}, 0);
        chk("rst_count",  {16'd0, word_count}, 0);
        chk("rst_busy",   {31'd0, busy}, 0);

        // 1: full-throughput stream of 8 words
        do_reset();
        load8();
        enable = 1'b1;
        bus.m_ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            chk("t1_rd_en", {31'd0, bus.fifo_rd_en}, {31'd0, k < 8});
            chk("t1_valid", {31'd0, bus.m_valid}, {31'd0, (k >= 2 && k <= 9)});
            if (k >= 2 && k <= 9) chk("t1_data", {24'd0, bus.m_data}, k - 1);
            if (k == 9) chk("t1_busy_last", {31'd0, busy}, 1);
            if (k == 10) begin
                chk("t1_busy_done", {31'd0, busy}, 0);
                chk("t1_count", {16'd0, word_count}, 8);
            end
        end
        @(posedge clk);
        #1;

        // 2: backpressure for 10 cycles
        do_reset();
        load8();
        enable = 1'b1;
        rd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) rd++;
            if (k >= 2) begin
                chk("t2_hold_valid", {31'd0, bus.m_valid}, 1);
                chk("t2_hold_data", {24'd0, bus.m_data}, 32'h01);
            end
        end
        chk("t2_rd_pulses", rd, 2);
        @(posedge clk);
        #1 bus.m_ready = 1'b1;
        wait_count(8, 30, "t2_count");
        repeat (2) @(posedge clk);
        #1;
        chk("t2_drained", rptr, wptr);
        chk("t2_busy", {31'd0, busy}, 0);

        // 3: empty FIFO, then a single word
        do_reset();
        enable = 1'b1;
        bus.m_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_idle_rd", {31'd0, bus.fifo_rd_en}, 0);
            chk("t3_idle_valid", {31'd0, bus.m_valid}, 0);
        end
        @(posedge clk);
        #1 push(8'h63);
        rd = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) rd++;
            if (bus.m_valid) chk("t3_data", {24'd0, bus.m_data}, 32'h63);
        end
        chk("t3_rd_pulses", rd, 1);
        chk("t3_count", {16'd0, word_count}, 1);
        chk("t3_busy", {31'd0, busy}, 0);
        @(posedge clk);
        #1;

        // 4: enable dropped after the third read
        do_reset();
        load8();
        enable = 1'b1;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 enable = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t4_count_partial", {16'd0, word_count}, 3);
        chk("t4_remaining", wptr - rptr, 5);
        chk("t4_busy_idle", {31'd0, busy}, 0);
        enable = 1'b1;
        wait_count(8, 30, "t4_count_all");
        repeat (2) @(posedge clk);
        #1;
        chk("t4_drained", rptr, wptr);

        // 5: m_ready toggling every cycle
        do_reset();
        load8();
        enable = 1'b1;
        c = 0;
        while (word_count != CW'(8) && c < 40) begin
            bus.m_ready = (c % 2 == 0);
            @(posedge clk);
            #1;
            c++;
        end
        chk("t5_count", {16'd0, word_count}, 8);
        bus.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t5_drained", rptr, wptr);

        // 6: reset with a full skid buffer
        do_reset();
        load8();
        enable = 1'b1;
        bus.m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 bus.m_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t6_pre_valid", {31'd0, bus.m_valid}, 1);
        chk("t6_pre_count", {16'd0, word_count}, 2);
        chk("t6_pre_full", rptr - exp_idx, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, bus.m_valid}, 0);
        chk("t6_rst_busy",  {31'd0, busy}, 0);
        chk("t6_rst_count", {16'd0, word_count}, 0);
        chk("t6_rst_rd_en", {31'd0, bus.fifo_rd_en}, 0);
        base = rptr;
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.m_ready = 1'b1;
        wait_count(wptr - base, 30, "t6_count_after");
        repeat (2) @(posedge clk);
        #1;
        chk("t6_drained", rptr, wptr);
        chk("t6_busy", {31'd0, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
